jt6295_enc: RTL



---
 rtl/jt6295_pkg.sv | 55 +++++
 rtl/jt6295_enc_pack.sv | 66 ++++++
 rtl/jt6295_enc.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/jt6295_pkg.sv
// Shared MSM6295 ADPCM definitions: step table, index deltas, PCM limits, encoder FSM states.
package jt6295_pkg;

  localparam int unsigned PCM_W   = 12;
  localparam int unsigned STEP_W  = 11;
  localparam int unsigned IDX_W   = 6;
  localparam int unsigned IDX_MAX = 48;

  localparam logic signed [PCM_W-1:0] PCM_MAX = 12'sh7FF;
  localparam logic signed [PCM_W-1:0] PCM_MIN = 12'sh800;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SUB,
    ST_Q2,
    ST_Q1,
    ST_Q0,
    ST_UPD
  } enc_state_t;

  // Quantiser step size for a given index (49 entries, 16..1552)
  function automatic logic [STEP_W-1:0] step_of(input logic [IDX_W-1:0] idx);
    logic [STEP_W-1:0] s;
    case (idx)
      6'd0:  s = 11'd16;   6'd1:  s = 11'd17;   6'd2:  s = 11'd19;   6'd3:  s = 11'd21;
      6'd4:  s = 11'd23;   6'd5:  s = 11'd25;   6'd6:  s = 11'd28;   6'd7:  s = 11'd31;
      6'd8:  s = 11'd34;   6'd9:  s = 11'd37;   6'd10: s = 11'd41;   6'd11: s = 11'd45;
      6'd12: s = 11'd50;   6'd13: s = 11'd55;   6'd14: s = 11'd60;   6'd15: s = 11'd66;
      6'd16: s = 11'd73;   6'd17: s = 11'd80;   6'd18: s = 11'd88;   6'd19: s = 11'd97;
      6'd20: s = 11'd107;  6'd21: s = 11'd118;  6'd22: s = 11'd130;  6'd23: s = 11'd143;
      6'd24: s = 11'd157;  6'd25: s = 11'd173;  6'd26: s = 11'd190;  6'd27: s = 11'd209;
      6'd28: s = 11'd230;  6'd29: s = 11'd253;  6'd30: s = 11'd279;  6'd31: s = 11'd307;
      6'd32: s = 11'd337;  6'd33: s = 11'd371;  6'd34: s = 11'd408;  6'd35: s = 11'd449;
      6'd36: s = 11'd494;  6'd37: s = 11'd544;  6'd38: s = 11'd598;  6'd39: s = 11'd658;
      6'd40: s = 11'd724;  6'd41: s = 11'd796;  6'd42: s = 11'd876;  6'd43: s = 11'd963;
      6'd44: s = 11'd1060; 6'd45: s = 11'd1166; 6'd46: s = 11'd1282; 6'd47: s = 11'd1411;
      default: s = 11'd1552;
    endcase
    return s;
  endfunction

  // Index adjustment for the magnitude bits of a code
  function automatic logic signed [4:0] delta_of(input logic [2:0] mag_code);
    logic signed [4:0] d;
    case (mag_code)
      3'd4:    d = 5'sd2;
      3'd5:    d = 5'sd4;
      3'd6:    d = 5'sd6;
      3'd7:    d = 5'sd8;
      default: d = -5'sd1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/jt6295_enc_pack.sv
// Nibble-to-byte packer: half register, output byte register with valid/ready, odd-nibble flush.
module jt6295_enc_pack
  import jt6295_pkg::*;
#(
  parameter int unsigned HI_FIRST = 1
)(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cen,
  input  logic       push,
  input  logic [3:0] nibble,
  input  logic       flush,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  input  logic       byte_ready,
  output logic       half_full,
  output logic       flush_pend,
  output logic       stall_c
);

  logic [3:0] half;
  logic       can_load;
  logic       do_flush;

  // First nibble of a pair lands in the high half when HI_FIRST is set
  function automatic logic [7:0] pack(input logic [3:0] first, input logic [3:0] second);
    return (HI_FIRST != 0) ? {first, second} : {second, first};
  endfunction

  // A completing push stalls only while the byte register stays occupied this cycle
  assign can_load = ~byte_valid | byte_ready;
  assign stall_c  = push & half_full & ~can_load;
  assign do_flush = (flush | flush_pend) & half_full & can_load;

  // Half/byte registers; a byte taken and a new byte loaded in the same cycle gives no bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      half       <= 4'h0;
      half_full  <= 1'b0;
      byte_out   <= 8'h00;
      byte_valid <= 1'b0;
      flush_pend <= 1'b0;
    end else if (cen) begin
      if (byte_valid && byte_ready) byte_valid <= 1'b0;
      if (push && !stall_c) begin
        if (half_full) begin
          byte_out   <= pack(half, nibble);
          byte_valid <= 1'b1;
          half_full  <= 1'b0;
        end else begin
          half      <= nibble;
          half_full <= 1'b1;
        end
      end
      if (do_flush) begin
        byte_out   <= pack(half, 4'h0);
        byte_valid <= 1'b1;
        half_full  <= 1'b0;
        flush_pend <= 1'b0;
      end else if (flush && half_full) begin
        flush_pend <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/jt6295_enc.sv
// MSM6295-compatible ADPCM encoder: 12-bit PCM in, packed 4-bit codes out.
// Optional feature macro: JT6295_ENC_ERR_EN adds the err_acc reconstruction-error accumulator.
module jt6295_enc
  import jt6295_pkg::*;
#(
  parameter int unsigned HI_FIRST = 1
`ifdef JT6295_ENC_ERR_EN
  , parameter int unsigned ERR_W = 24
`endif
)(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cen,
  input  logic             clr,
  input  logic             flush,
  input  logic [PCM_W-1:0] pcm_in,
  input  logic             pcm_valid,
  output logic             pcm_ready,
  output logic [7:0]       byte_out,
  output logic             byte_valid,
  input  logic             byte_ready,
  output logic             busy
`ifdef JT6295_ENC_ERR_EN
  , output logic [ERR_W-1:0] err_acc
`endif
);

  enc_state_t state, state_nxt;

  logic                    run;
  logic signed [PCM_W-1:0] pcm_r;
  logic signed [PCM_W-1:0] pred;
  logic [IDX_W-1:0]        idx;
  logic [STEP_W-1:0]       step;
  logic [PCM_W-1:0]        mag;
  logic                    sgn, b2, b1, b0;

  logic                    half_full, flush_pend, stall_c;
  logic                    in_idle, accept, flush_go;

  logic signed [PCM_W:0]   d;
  logic [PCM_W-1:0]        mag_abs;
  logic [PCM_W-1:0]        diff;
  logic signed [PCM_W+1:0] psum;
  logic signed [PCM_W-1:0] pred_nxt;
  logic signed [4:0]       dlt;
  logic signed [IDX_W:0]   idx_sum;
  logic [IDX_W-1:0]        idx_nxt;

  // Handshake: ready only after reset release, in IDLE, with no flush requested or pending
  assign in_idle   = (state == ST_IDLE);
  assign pcm_ready = run & in_idle & ~flush_pend & ~flush;
  assign accept    = cen & pcm_valid & pcm_ready;
  assign flush_go  = flush & in_idle;
  assign busy      = ~in_idle | half_full;

  // Difference and magnitude (|d| <= 4095 always fits 12 bits)
  assign d       = 13'(pcm_r) - 13'(pred);
  assign mag_abs = 12'(d[PCM_W] ? -d : d);

  // Reconstruction exactly as the decoder computes it
  assign diff = 12'(step >> 3)
              + (b2 ? 12'(step)      : 12'd0)
              + (b1 ? 12'(step >> 1) : 12'd0)
              + (b0 ? 12'(step >> 2) : 12'd0);
  assign psum = sgn ? 14'(pred) - signed'({2'b00, diff})
                    : 14'(pred) + signed'({2'b00, diff});
  assign pred_nxt = (psum > 14'(PCM_MAX)) ? PCM_MAX :
                    (psum < 14'(PCM_MIN)) ? PCM_MIN : psum[PCM_W-1:0];

  assign dlt     = delta_of({b2, b1, b0});
  assign idx_sum = signed'({1'b0, idx}) + 7'(dlt);
  assign idx_nxt = idx_sum[IDX_W]                        ? '0 :
                   (idx_sum[IDX_W-1:0] > IDX_W'(IDX_MAX)) ? IDX_W'(IDX_MAX) : idx_sum[IDX_W-1:0];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next state: one step per cen cycle, UPD holds while the packer stalls
  always_comb begin
    state_nxt = state;
    if (cen) begin
      case (state)
        ST_IDLE: if (pcm_valid && pcm_ready) state_nxt = ST_SUB;
        ST_SUB:  state_nxt = ST_Q2;
        ST_Q2:   state_nxt = ST_Q1;
        ST_Q1:   state_nxt = ST_Q0;
        ST_Q0:   state_nxt = ST_UPD;
        ST_UPD:  if (!stall_c) state_nxt = ST_IDLE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

`ifdef JT6295_ENC_ERR_EN
  logic signed [PCM_W:0] e;
  logic [PCM_W-1:0]      e_abs;
  logic [ERR_W:0]        err_sum;

  assign e       = 13'(pcm_r) - 13'(pred_nxt);
  assign e_abs   = 12'(e[PCM_W] ? -e : e);
  assign err_sum = {1'b0, err_acc} + (ERR_W+1)'(e_abs);

  // Saturating |pcm - reconstruction| accumulator
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_acc <= '0;
    end else if (cen) begin
      if (in_idle && clr) err_acc <= '0;
      else if (state == ST_UPD && !stall_c)
        err_acc <= err_sum[ERR_W] ? '1 : err_sum[ERR_W-1:0];
    end
  end
`endif

  // Sequential quantiser datapath and predictor/index state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run   <= 1'b0;
      pcm_r <= '0;
      pred  <= '0;
      idx   <= '0;
      step  <= '0;
      mag   <= '0;
      sgn   <= 1'b0;
      b2    <= 1'b0;
      b1    <= 1'b0;
      b0    <= 1'b0;
    end else begin
      run <= 1'b1;
      if (cen) begin
        case (state)
          ST_IDLE: begin
            if (clr) begin
              pred <= '0;
              idx  <= '0;
            end
            if (accept) pcm_r <= pcm_in;
          end
          ST_SUB: begin
            sgn  <= d[PCM_W];
            mag  <= mag_abs;
            step <= step_of(idx);
          end
          ST_Q2: begin
            b2 <= (mag >= 12'(step));
            if (mag >= 12'(step)) mag <= mag - 12'(step);
          end
          ST_Q1: begin
            b1 <= (mag >= 12'(step >> 1));
            if (mag >= 12'(step >> 1)) mag <= mag - 12'(step >> 1);
          end
          ST_Q0: b0 <= (mag >= 12'(step >> 2));
          ST_UPD: begin
            if (!stall_c) begin
              pred <= pred_nxt;
              idx  <= idx_nxt;
            end
          end
          default: ;
        endcase
      end
    end
  end

  jt6295_enc_pack #(.HI_FIRST(HI_FIRST)) u_pack (
    .clk        (clk),
    .rst_n      (rst_n),
    .cen        (cen),
    .push       (state == ST_UPD),
    .nibble     ({sgn, b2, b1, b0}),
    .flush      (flush_go),
    .byte_out   (byte_out),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .half_full  (half_full),
    .flush_pend (flush_pend),
    .stall_c    (stall_c)
  );

endmodule
